// File: rtl/gate_delay_array_pkg.sv
// Shared definitions for gate_delay_array: opcode encoding, the gate
// evaluation function and the statistics counter width.
// Optional feature macro: GATE_DELAY_ARRAY_STATS_EN (per-channel ones counters).
package gate_delay_array_pkg;

  localparam int STAT_W = 16;

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_NAND = 3'd1,
    OP_OR   = 3'd2,
    OP_NOR  = 3'd3,
    OP_XOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_BUF  = 3'd6,
    OP_NOT  = 3'd7
  } op_e;

  // Reductions are computed by the caller so the function stays width-agnostic.
  function automatic logic eval_op(input logic [2:0] op,
                                   input logic red_and,
                                   input logic red_or,
                                   input logic red_xor,
                                   input logic bit0);
    logic res;
    case (op_e'(op))
      OP_AND:  res = red_and;
      OP_NAND: res = ~red_and;
      OP_OR:   res = red_or;
      OP_NOR:  res = ~red_or;
      OP_XOR:  res = red_xor;
      OP_XNOR: res = ~red_xor;
      OP_BUF:  res = bit0;
      OP_NOT:  res = ~bit0;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/gate_delay_lane.sv
// One gate_delay_array channel: config register, stage 0 gate register,
// MAX_DLY-deep {valid,data} delay line, tap mux and output register.
// Optional feature macro: GATE_DELAY_ARRAY_STATS_EN (adds stat_ones counter).
module gate_delay_lane
  import gate_delay_array_pkg::*;
#(
  parameter int IN_W    = 4,
  parameter int MAX_DLY = 7,
  parameter int DLY_W   = $clog2(MAX_DLY + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [2:0]        op_in,
  input  logic [DLY_W-1:0]  dly_in,
  input  logic              in_valid,
  input  logic [IN_W-1:0]   in_data,
  output logic              out_valid,
  output logic              out_data,
  output logic              clamp_hit
`ifdef GATE_DELAY_ARRAY_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_ones
`endif
);

  localparam logic [DLY_W-1:0] MAX_DLY_V = DLY_W'(MAX_DLY);

  logic [2:0]       op_q;
  logic [DLY_W-1:0] dly_q;
  logic [DLY_W-1:0] dly_sat;
  logic             gate_res;
  // bit 0 is stage 0; bit i is stage 0 delayed by i cycles
  logic [MAX_DLY:0] pipe_v;
  logic [MAX_DLY:0] pipe_d;
  logic             tap_v;
  logic             tap_d;

  assign clamp_hit = cfg_we && (dly_in > MAX_DLY_V);
  assign dly_sat   = clamp_hit ? MAX_DLY_V : dly_in;
  assign gate_res  = eval_op(op_q, &in_data, |in_data, ^in_data, in_data[0]);
  assign tap_v     = pipe_v[dly_q];
  assign tap_d     = pipe_d[dly_q];

  // Config register; values written here apply from the next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q  <= OP_AND;
      dly_q <= '0;
    end else if (cfg_we) begin
      op_q  <= op_in;
      dly_q <= dly_sat;
    end
  end

  // Stage 0 plus delay line; a config write flushes every valid bit, which
  // also drops any sample presented on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_v <= '0;
      pipe_d <= '0;
    end else begin
      if (cfg_we) begin
        pipe_v <= '0;
      end else begin
        pipe_v <= {pipe_v[MAX_DLY-1:0], in_valid};
      end
      pipe_d <= {pipe_d[MAX_DLY-1:0], (in_valid && !cfg_we) ? gate_res : pipe_d[0]};
    end
  end

  // Output register; data holds while no valid sample reaches the tap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= 1'b0;
    end else begin
      out_valid <= tap_v && !cfg_we;
      if (tap_v && !cfg_we) begin
        out_data <= tap_d;
      end
    end
  end

`ifdef GATE_DELAY_ARRAY_STATS_EN
  // Saturating count of cycles presenting a valid one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_ones <= '0;
    end else if (cfg_we) begin
      stat_ones <= '0;
    end else if (out_valid && out_data && (stat_ones != {STAT_W{1'b1}})) begin
      stat_ones <= stat_ones + 1'b1;
    end
  end
`endif

endmodule

// File: rtl/gate_delay_array.sv
// Multi-channel gate array: each lane reduces its inputs through a selectable
// gate and delays the result by a programmable number of cycles.
// Optional feature macro: GATE_DELAY_ARRAY_STATS_EN (adds stat_ones port).
module gate_delay_array
  import gate_delay_array_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int IN_W     = 4,
  parameter int MAX_DLY  = 7,
  parameter int DLY_W    = $clog2(MAX_DLY + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cfg_we,
  input  logic [3*CHANNELS-1:0]     op_cfg,
  input  logic [DLY_W*CHANNELS-1:0] dly_cfg,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic [IN_W*CHANNELS-1:0]  in_data,
  output logic [CHANNELS-1:0]       out_valid,
  output logic [CHANNELS-1:0]       out_data,
  output logic                      cfg_err
`ifdef GATE_DELAY_ARRAY_STATS_EN
  ,
  output logic [STAT_W*CHANNELS-1:0] stat_ones
`endif
);

  logic [CHANNELS-1:0] clamp_hit;

  for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
    gate_delay_lane #(
      .IN_W    (IN_W),
      .MAX_DLY (MAX_DLY),
      .DLY_W   (DLY_W)
    ) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .cfg_we    (cfg_we),
      .op_in     (op_cfg[3*k +: 3]),
      .dly_in    (dly_cfg[DLY_W*k +: DLY_W]),
      .in_valid  (in_valid[k]),
      .in_data   (in_data[IN_W*k +: IN_W]),
      .out_valid (out_valid[k]),
      .out_data  (out_data[k]),
      .clamp_hit (clamp_hit[k])
`ifdef GATE_DELAY_ARRAY_STATS_EN
      ,
      .stat_ones (stat_ones[STAT_W*k +: STAT_W])
`endif
    );
  end

  // Sticky out-of-range delay flag; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_err <= 1'b0;
    end else if (|clamp_hit) begin
      cfg_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_gate_delay_array.sv
// Directed self-checking bench for gate_delay_array. A second instance with
// MAX_DLY=5 exercises delay clamping.
module tb_gate_delay_array;

  logic        clk;
  logic        rst_n;

  logic        cfg_we;
  logic [11:0] op_cfg;
  logic [11:0] dly_cfg;
  logic [3:0]  in_valid;
  logic [15:0] in_data;
  logic [3:0]  out_valid;
  logic [3:0]  out_data;
  logic        cfg_err;

  logic        cfg_we5;
  logic [11:0] op_cfg5;
  logic [11:0] dly_cfg5;
  logic [3:0]  in_valid5;
  logic [15:0] in_data5;
  logic [3:0]  out_valid5;
  logic [3:0]  out_data5;
  logic        cfg_err5;

`ifdef GATE_DELAY_ARRAY_STATS_EN
  logic [63:0] stat_ones;
  logic [63:0] stat_ones5;
`endif

  int total = 0;
  int bad   = 0;

  gate_delay_array #(.CHANNELS(4), .IN_W(4), .MAX_DLY(7)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_we    (cfg_we),
    .op_cfg    (op_cfg),
    .dly_cfg   (dly_cfg),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_data  (out_data),
    .cfg_err   (cfg_err)
`ifdef GATE_DELAY_ARRAY_STATS_EN
    ,
    .stat_ones (stat_ones)
`endif
  );

  gate_delay_array #(.CHANNELS(4), .IN_W(4), .MAX_DLY(5)) dut5 (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_we    (cfg_we5),
    .op_cfg    (op_cfg5),
    .dly_cfg   (dly_cfg5),
    .in_valid  (in_valid5),
    .in_data   (in_data5),
    .out_valid (out_valid5),
    .out_data  (out_data5),
    .cfg_err   (cfg_err5)
`ifdef GATE_DELAY_ARRAY_STATS_EN
    ,
    .stat_ones (stat_ones5)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0] op_exp;
    op_exp = 8'b0101_0110;

    rst_n     = 1'b0;
    cfg_we    = 1'b0;
    op_cfg    = '0;
    dly_cfg   = '0;
    in_valid  = '0;
    in_data   = '0;
    cfg_we5   = 1'b0;
    op_cfg5   = '0;
    dly_cfg5  = '0;
    in_valid5 = '0;
    in_data5  = '0;
    tick();
    tick();
    chk("rst_out_valid", {28'b0, out_valid}, 32'h0);
    chk("rst_out_data", {28'b0, out_data}, 32'h0);
    chk("rst_cfg_err", {31'b0, cfg_err}, 32'h0);
    rst_n = 1'b1;
    tick();

    // AND, dly 0: sample appears exactly two cycles later
    in_valid[0]   = 1'b1;
    in_data[3:0]  = 4'hF;
    tick();
    in_valid = '0;
    chk("and_lat1_valid", {31'b0, out_valid[0]}, 32'h0);
    tick();
    chk("and_lat2_valid", {31'b0, out_valid[0]}, 32'h1);
    chk("and_lat2_data", {31'b0, out_data[0]}, 32'h1);
    tick();
    chk("and_lat3_valid", {31'b0, out_valid[0]}, 32'h0);
    chk("and_hold_data", {31'b0, out_data[0]}, 32'h1);

    // mid-stream async reset clears outputs without a clock edge
    in_valid[0] = 1'b1;
    tick();
    tick();
    chk("stream_valid", {31'b0, out_valid[0]}, 32'h1);
    rst_n    = 1'b0;
    in_valid = '0;
    #1;
    chk("async_rst_valid", {28'b0, out_valid}, 32'h0);
    chk("async_rst_data", {28'b0, out_data}, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    chk("post_rst_no_valid", {28'b0, out_valid}, 32'h0);

    // opcode sweep on channel 1 with inputs 0111
    for (int op = 0; op < 8; op++) begin
      cfg_we        = 1'b1;
      op_cfg[5:3]   = 3'(op);
      dly_cfg       = '0;
      tick();
      cfg_we        = 1'b0;
      in_valid[1]   = 1'b1;
      in_data[7:4]  = 4'b0111;
      tick();
      in_valid      = '0;
      tick();
      chk($sformatf("op%0d_valid", op), {31'b0, out_valid[1]}, 32'h1);
      chk($sformatf("op%0d_data", op), {31'b0, out_data[1]}, {31'b0, op_exp[op]});
    end
    tick();
    chk("op_hold_valid", {31'b0, out_valid[1]}, 32'h0);
    chk("op_hold_data", {31'b0, out_data[1]}, 32'h0);

    // delay sweep on channel 2, XOR of 0001
    for (int d = 0; d < 8; d++) begin
      cfg_we         = 1'b1;
      op_cfg[8:6]    = 3'd4;
      dly_cfg[8:6]   = 3'(d);
      tick();
      cfg_we         = 1'b0;
      in_valid[2]    = 1'b1;
      in_data[11:8]  = 4'b0001;
      tick();
      in_valid       = '0;
      chk($sformatf("dly%0d_c1", d), {31'b0, out_valid[2]}, 32'h0);
      for (int c = 2; c <= d + 3; c++) begin
        tick();
        chk($sformatf("dly%0d_c%0d_valid", d, c), {31'b0, out_valid[2]}, {31'b0, c == d + 2});
        if (c == d + 2)
          chk($sformatf("dly%0d_data", d), {31'b0, out_data[2]}, 32'h1);
      end
    end

    // config flush: write mid-stream drops every in-flight sample
    cfg_we  = 1'b1;
    op_cfg  = {4{3'd2}};
    dly_cfg = {4{3'd5}};
    tick();
    cfg_we   = 1'b0;
    in_data  = 16'hFFFF;
    in_valid = 4'hF;
    tick();
    tick();
    tick();
    cfg_we = 1'b1;
    tick();
    cfg_we   = 1'b0;
    in_valid = '0;
    for (int c = 0; c < 10; c++) begin
      chk($sformatf("flush_c%0d", c), {28'b0, out_valid}, 32'h0);
      tick();
    end
    in_valid[0] = 1'b1;
    tick();
    in_valid = '0;
    for (int c = 2; c <= 8; c++) begin
      tick();
      chk($sformatf("post_flush_c%0d", c), {31'b0, out_valid[0]}, {31'b0, c == 7});
    end
    chk("no_err_in_range", {31'b0, cfg_err}, 32'h0);

    // clamp on the MAX_DLY=5 instance: 7 -> 5, latency 7
    cfg_we5          = 1'b1;
    dly_cfg5[11:9]   = 3'd7;
    tick();
    cfg_we5          = 1'b0;
    chk("clamp_err_set", {31'b0, cfg_err5}, 32'h1);
    in_valid5[3]     = 1'b1;
    in_data5[15:12]  = 4'hF;
    tick();
    in_valid5 = '0;
    for (int c = 2; c <= 9; c++) begin
      tick();
      chk($sformatf("clamp_c%0d", c), {31'b0, out_valid5[3]}, {31'b0, c == 7});
    end
    cfg_we5  = 1'b1;
    dly_cfg5 = '0;
    tick();
    cfg_we5 = 1'b0;
    tick();
    chk("clamp_err_sticky", {31'b0, cfg_err5}, 32'h1);

`ifdef GATE_DELAY_ARRAY_STATS_EN
    cfg_we  = 1'b1;
    op_cfg  = '0;
    dly_cfg = '0;
    tick();
    cfg_we       = 1'b0;
    in_data[3:0] = 4'hF;
    in_valid[0]  = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    in_valid = '0;
    tick();
    tick();
    tick();
    chk("stat_20", {16'b0, stat_ones[15:0]}, 32'd20);
    cfg_we = 1'b1;
    tick();
    cfg_we = 1'b0;
    chk("stat_clr", {16'b0, stat_ones[15:0]}, 32'd0);
`endif

    rst_n = 1'b0;
    #1;
    chk("final_rst_err", {31'b0, cfg_err5}, 32'h0);
    chk("final_rst_valid", {28'b0, out_valid5}, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gate_delay_array.md
Name: gate_delay_array

Overview:
- Parametrised multi-channel logic-gate array.
- Each channel reduces an IN_W-bit input vector through a runtime-selectable primitive gate function (AND, NAND, OR, NOR, XOR, XNOR, BUF, NOT).
- Each channel then delays the 1-bit result by a per-channel programmable number of clock cycles.
- Synthesisable successor to the fixed gate and #delay test structures. It serves as a clocked stimulus/reference source for gate-level comparison benches.

Parameters:
- CHANNELS, 4, number of independent gate channels.
- IN_W, 4, gate input count per channel (min 2).
- MAX_DLY, 7, maximum extra delay in clock cycles per channel (min 1).
- DLY_W, $clog2(MAX_DLY+1), width of one delay field (derived; do not override).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cfg_we  in  1  load op_cfg/dly_cfg into the config registers.
- op_cfg  in  3*CHANNELS  per-channel opcode, channel k at [3k+2:3k].
- dly_cfg  in  DLY_W*CHANNELS  per-channel extra delay, channel k at [DLY_W*k +: DLY_W].
- in_valid  in  CHANNELS  per-channel sample strobe.
- in_data  in  IN_W*CHANNELS  channel k inputs at [IN_W*k +: IN_W].
- out_valid  out  CHANNELS  per-channel result strobe.
- out_data  out  CHANNELS  per-channel gate result.
- cfg_err  out  1  sticky: a dly_cfg field > MAX_DLY was written.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - out_valid=0, out_data=0, cfg_err=0.
  - All opcodes=0 (AND), all delays=0.
  - All delay-line bits and valid bits cleared.
- Opcodes:
  - 0=AND, 1=NAND, 2=OR, 3=NOR, 4=XOR (odd parity), 5=XNOR.
  - 6=BUF: passes in_data bit 0 of the channel.
  - 7=NOT: inverts in_data bit 0 of the channel.
- Stage 0:
  - On in_valid[k], the reduced result and valid=1 are registered.
  - Without in_valid[k], valid=0 is registered and the data bit holds.
- Delay line:
  - Each channel has a MAX_DLY-deep shift register of {valid,data} after stage 0, shifting every cycle.
  - Output tap = element dly[k]; dly=0 taps stage 0.
  - out_valid/out_data are registered from the tap.
  - Total latency in_valid→out_valid = dly[k]+2 cycles.
  - Full throughput: one sample per channel per cycle, no backpressure.
- Config write (cfg_we=1):
  - New opcodes/delays take effect the following cycle.
  - Every channel's stage 0, delay line, and output valid bits are flushed to 0 on the same edge, so no sample straddles a config change.
  - in_valid coincident with cfg_we is dropped.
  - A delay field > MAX_DLY is clamped to MAX_DLY and sets cfg_err, which clears only on reset.
- Channels are fully independent; differing delays reorder nothing within a channel.
- out_data holds its last value while out_valid=0.
- Reset mid-stream discards all in-flight samples immediately.

Optional Feature:
- Macro: GATE_DELAY_ARRAY_STATS_EN.
- When defined:
  - Adds output port stat_ones (16*CHANNELS). Per channel, a 16-bit saturating count of cycles with out_valid=1 and out_data=1.
  - Counters reset to 0 on rst_n and on cfg_we, and saturate at 16'hFFFF.
- When undefined: the port and counters are absent; all other behaviour is identical.

Decomposition:
- Package gate_delay_array_pkg holds:
  - opcode enum/localparams (OP_AND..OP_NOT, 3 bits);
  - the opcode-evaluation function;
  - the STAT_W=16 constant.
- Sub-module gate_delay_lane holds one channel: config register, stage 0, delay line, tap mux, output register, and optional counter.
- The top generates CHANNELS lanes and ORs the per-lane clamp flags into cfg_err.

Test Plan:
- Reset check: CHANNELS=4, IN_W=4, MAX_DLY=7; rst_n low mid-run → all outputs 0 immediately. After release with op=AND, dly=0, in_data ch0=4'hF with valid → out_valid[0]=1, out_data[0]=1 exactly 2 cycles later.
- Opcode sweep on ch1, in_data=4'b0111, dly=0, ops 0..7 → results 0,1,1,0,1,0,1,0 respectively.
- Delay sweep on ch2 (op=XOR): for dly=0..7, single pulse in_data=4'b0001 → out_valid[2] at cycle dly+2 with data=1, valid only that cycle.
- Config flush: streams on all channels with dly=5. Issue cfg_we at cycle 3 of the stream → no out_valid for the pre-config samples. in_valid coincident with cfg_we produces no output.
- Clamp: write dly_cfg ch3=7 with MAX_DLY=5 → effective latency 7 cycles and cfg_err=1, sticky until reset.
- With GATE_DELAY_ARRAY_STATS_EN: 20 valid ones on ch0 → stat_ones[15:0]=20. cfg_we → 0. Force 70000 valid ones → holds 16'hFFFF.
